// File: rtl/adder_load_controller.sv
// -----------------------------------------------------------------------------
// adder_load_controller
//
// Sequences operand entry and a bit-serial 7-bit addition for the adder lab
// board. Two raw pushbuttons ("next" and "clear") are synchronized, debounced
// and turned into single-cycle press pulses. A press of "next" loads the
// switch bus into successive nibbles of A and B. After the last nibble the
// controller adds A+B one bit per clock and holds the result for the LEDs.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable synchronized samples required to
//                     accept a button level change (>= 2)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   pb_next      in   raw "next" pushbutton (asynchronous, bouncy)
//   pb_clear     in   raw "clear" pushbutton (asynchronous, bouncy)
//   y[3:0]       in   switch bus, sampled on an accepted next press
//   a_out[6:0]   out  operand A register
//   b_out[6:0]   out  operand B register
//   sum[6:0]     out  result register (intermediate bits visible during add)
//   cout         out  carry out of bit 6
//   result_valid out  high while sum/cout hold a completed result
//   state_led    out  current FSM state code
// -----------------------------------------------------------------------------
module adder_load_controller #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pb_next,
   input  logic       pb_clear,
   input  logic [3:0] y,
   output logic [6:0] a_out,
   output logic [6:0] b_out,
   output logic [6:0] sum,
   output logic       cout,
   output logic       result_valid,
   output logic [2:0] state_led
);

   // Index of each button inside the conditioner arrays.
   localparam int BTN_NEXT  = 0;
   localparam int BTN_CLEAR = 1;

   // Counter value on which the next mismatching sample completes the debounce.
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_A_LO = 3'd0,
      S_A_HI = 3'd1,
      S_B_LO = 3'd2,
      S_B_HI = 3'd3,
      S_ADD  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   // ---------------------------------------------------------------------------
   // Bit-serial adder helpers
   // ---------------------------------------------------------------------------
   function automatic logic f_sum_bit(input logic x, input logic z, input logic c);
      return x ^ z ^ c;
   endfunction

   function automatic logic f_majority(input logic x, input logic z, input logic c);
      return (x & z) | (x & c) | (z & c);
   endfunction

   // ---------------------------------------------------------------------------
   // Button conditioning: synchronizer -> debouncer -> rising-edge detector
   // ---------------------------------------------------------------------------
   logic [1:0]       w_raw;
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_deb;
   logic [1:0]       r_deb_d;
   logic [CNT_W-1:0] r_cnt [2];
   logic [1:0]       w_press;
   logic             w_next_press;
   logic             w_clear_press;

   assign w_raw[BTN_NEXT]  = pb_next;
   assign w_raw[BTN_CLEAR] = pb_clear;

   // Synchronize, debounce and delay both buttons.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 2'b00;
         r_sync2 <= 2'b00;
         r_deb   <= 2'b00;
         r_deb_d <= 2'b00;
         for (int k = 0; k < 2; k++) begin
            r_cnt[k] <= '0;
         end
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_deb_d <= r_deb;
         for (int k = 0; k < 2; k++) begin
            if (r_sync2[k] == r_deb[k]) begin
               r_cnt[k] <= '0;
            end else if (r_cnt[k] == DB_LAST) begin
               // This sample is the DEBOUNCE_CYCLES-th consecutive mismatch.
               r_deb[k] <= r_sync2[k];
               r_cnt[k] <= '0;
            end else begin
               r_cnt[k] <= r_cnt[k] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   // Only a 0->1 change of the debounced level is a press; releases are silent.
   assign w_press       = r_deb & ~r_deb_d;
   assign w_next_press  = w_press[BTN_NEXT];
   assign w_clear_press = w_press[BTN_CLEAR];

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   state_t     r_state;
   state_t     w_next_state;
   logic [6:0] r_a;
   logic [6:0] r_b;
   logic [6:0] r_sum;
   logic       r_cout;
   logic       r_valid;
   logic       r_carry;
   logic [2:0] r_idx;

   // Per-cycle control decoded from the current state.
   logic w_ld_a_lo;
   logic w_ld_a_hi;
   logic w_ld_b_lo;
   logic w_ld_b_hi;
   logic w_add_step;
   logic w_add_last;
   logic w_done_ack;
   logic w_clr_all;

   // Current operand bits for the serial add; zero-extended so an index of 7
   // never selects outside the vector.
   logic [7:0] w_a_ext;
   logic [7:0] w_b_ext;
   logic       w_a_bit;
   logic       w_b_bit;
   logic       w_sum_bit;
   logic       w_carry_nxt;

   assign w_a_ext     = {1'b0, r_a};
   assign w_b_ext     = {1'b0, r_b};
   assign w_a_bit     = w_a_ext[r_idx];
   assign w_b_bit     = w_b_ext[r_idx];
   assign w_sum_bit   = f_sum_bit(w_a_bit, w_b_bit, r_carry);
   assign w_carry_nxt = f_majority(w_a_bit, w_b_bit, r_carry);

   // ---------------------------------------------------------------------------
   // FSM process 1: state register
   // ---------------------------------------------------------------------------
   // Hold the current state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_A_LO;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM process 2: next-state logic
   // ---------------------------------------------------------------------------
   // Clear overrides everything, including a simultaneous next press.
   always_comb begin
      w_next_state = r_state;
      if (w_clear_press) begin
         w_next_state = S_A_LO;
      end else begin
         case (r_state)
            S_A_LO: begin
               if (w_next_press) w_next_state = S_A_HI;
               else              w_next_state = S_A_LO;
            end
            S_A_HI: begin
               if (w_next_press) w_next_state = S_B_LO;
               else              w_next_state = S_A_HI;
            end
            S_B_LO: begin
               if (w_next_press) w_next_state = S_B_HI;
               else              w_next_state = S_B_LO;
            end
            S_B_HI: begin
               if (w_next_press) w_next_state = S_ADD;
               else              w_next_state = S_B_HI;
            end
            S_ADD: begin
               // Next presses are dropped here; the add always runs 7 cycles.
               if (r_idx == 3'd6) w_next_state = S_DONE;
               else               w_next_state = S_ADD;
            end
            S_DONE: begin
               if (w_next_press) w_next_state = S_A_LO;
               else              w_next_state = S_DONE;
            end
            default: begin
               // Codes 6 and 7 recover to the first load state.
               w_next_state = S_A_LO;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FSM process 3: output / datapath control decode
   // ---------------------------------------------------------------------------
   // Translate state plus button pulses into datapath load/step strobes.
   always_comb begin
      w_ld_a_lo  = 1'b0;
      w_ld_a_hi  = 1'b0;
      w_ld_b_lo  = 1'b0;
      w_ld_b_hi  = 1'b0;
      w_add_step = 1'b0;
      w_add_last = 1'b0;
      w_done_ack = 1'b0;
      w_clr_all  = 1'b0;
      if (w_clear_press) begin
         w_clr_all = 1'b1;
      end else begin
         case (r_state)
            S_A_LO:  w_ld_a_lo  = w_next_press;
            S_A_HI:  w_ld_a_hi  = w_next_press;
            S_B_LO:  w_ld_b_lo  = w_next_press;
            S_B_HI:  w_ld_b_hi  = w_next_press;
            S_ADD: begin
               w_add_step = 1'b1;
               w_add_last = (r_idx == 3'd6);
            end
            S_DONE:  w_done_ack = w_next_press;
            default: w_clr_all  = 1'b0;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Operand, sum and status registers
   // ---------------------------------------------------------------------------
   // Load operand nibbles, step the serial adder and track result validity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= 7'd0;
         r_b     <= 7'd0;
         r_sum   <= 7'd0;
         r_cout  <= 1'b0;
         r_valid <= 1'b0;
         r_carry <= 1'b0;
         r_idx   <= 3'd0;
      end else if (w_clr_all) begin
         r_a     <= 7'd0;
         r_b     <= 7'd0;
         r_sum   <= 7'd0;
         r_cout  <= 1'b0;
         r_valid <= 1'b0;
         r_carry <= 1'b0;
         r_idx   <= 3'd0;
      end else begin
         if (w_ld_a_lo) begin
            r_a[3:0] <= y;
         end else if (w_ld_a_hi) begin
            // Only three bits remain in the high part; y[3] is dropped.
            r_a[6:4] <= y[2:0];
         end else if (w_ld_b_lo) begin
            r_b[3:0] <= y;
         end else if (w_ld_b_hi) begin
            r_b[6:4] <= y[2:0];
            r_sum    <= 7'd0;
            r_carry  <= 1'b0;
            r_idx    <= 3'd0;
            r_valid  <= 1'b0;
         end else if (w_add_step) begin
            for (int k = 0; k < 7; k++) begin
               if (r_idx == 3'(k)) begin
                  r_sum[k] <= w_sum_bit;
               end else begin
                  r_sum[k] <= r_sum[k];
               end
            end
            r_carry <= w_carry_nxt;
            r_idx   <= r_idx + 3'd1;
            if (w_add_last) begin
               r_cout  <= w_carry_nxt;
               r_valid <= 1'b1;
            end else begin
               r_valid <= r_valid;
            end
         end else if (w_done_ack) begin
            // Operands and result are kept so a reload can change one nibble.
            r_valid <= 1'b0;
         end else begin
            r_valid <= r_valid;
         end
      end
   end

   assign a_out        = r_a;
   assign b_out        = r_b;
   assign sum          = r_sum;
   assign cout         = r_cout;
   assign result_valid = r_valid;
   assign state_led    = r_state;

endmodule

// File: tb/tb_adder_load_controller.sv
module tb_adder_load_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pb_next;
   logic       pb_clear;
   logic [3:0] y;
   logic [6:0] a_out, b_out, sum;
   logic       cout, result_valid;
   logic [2:0] state_led;

   // Second instance with a short debounce so that a full press can land
   // while the add sequence is still running.
   logic       pb_next2;
   logic       pb_clear2;
   logic [6:0] a2, b2, sum2;
   logic       cout2, rv2;
   logic [2:0] st2;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [6:0] s;
      logic       c;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   adder_load_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) u_dut (
      .clk(clk), .rst_n(rst_n), .pb_next(pb_next), .pb_clear(pb_clear), .y(y),
      .a_out(a_out), .b_out(b_out), .sum(sum), .cout(cout),
      .result_valid(result_valid), .state_led(state_led)
   );

   adder_load_controller #(.DEBOUNCE_CYCLES(2), .CNT_W(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .pb_next(pb_next2), .pb_clear(pb_clear2), .y(y),
      .a_out(a2), .b_out(b2), .sum(sum2), .cout(cout2),
      .result_valid(rv2), .state_led(st2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
      end
   endtask

   // Full next press on the main DUT: held long enough to be accepted, then released.
   task automatic press(input logic [3:0] v);
      @(negedge clk);
      y = v;
      pb_next = 1'b1;
      repeat (10) @(negedge clk);
      pb_next = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic press2(input logic [3:0] v);
      @(negedge clk);
      y = v;
      pb_next2 = 1'b1;
      repeat (6) @(negedge clk);
      pb_next2 = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic wait_state(input logic [2:0] v, input int budget, input string name);
      for (int i = 0; i < budget && state_led != v; i++) @(negedge clk);
      check(name, state_led, v);
   endtask

   // Monitor: on each rising result_valid, pop the expected result and compare.
   initial begin : monitor
      int   add_cnt;
      logic rv_prev;
      exp_t e;
      add_cnt = 0;
      rv_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            add_cnt = 0;
            rv_prev = 1'b0;
         end else begin
            if (result_valid && !rv_prev) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_result", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_sum", sum, e.s);
                  check("sb_cout", cout, e.c);
                  check("sb_state_done", state_led, 3'd5);
                  check("sb_add_cycles", add_cnt, 7);
               end
            end
            if (state_led == 3'd4) add_cnt++;
            else                   add_cnt = 0;
            rv_prev = result_valid;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int         n_tr;
      logic [2:0] prev;
      int         add2;
      rst_n = 1'b0; pb_next = 1'b0; pb_clear = 1'b0; y = 4'h0;
      pb_next2 = 1'b0; pb_clear2 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", state_led, 3'd0);
      check("rst_a", a_out, 7'h00);
      check("rst_b", b_out, 7'h00);
      check("rst_sum", sum, 7'h00);
      check("rst_cout_valid", {cout, result_valid}, 2'b00);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Bounce: 3 high / 3 low never satisfies a 4-sample debounce.
      y = 4'h7;
      for (int i = 0; i < 10; i++) begin
         pb_next = 1'b1; repeat (3) @(negedge clk);
         pb_next = 1'b0; repeat (3) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check("bounce_state", state_led, 3'd0);
      check("bounce_a", a_out, 7'h00);

      // Held high: exactly one transition, loads A[3:0]=0xB.
      y = 4'hB;
      pb_next = 1'b1;
      n_tr = 0;
      prev = state_led;
      repeat (30) begin
         @(negedge clk);
         if (state_led != prev) n_tr++;
         prev = state_led;
      end
      check("hold_one_press", n_tr, 1);
      check("hold_state", state_led, 3'd1);
      pb_next = 1'b0;
      repeat (10) @(negedge clk);

      // Basic add: 0x2B + 0x19 = 0x44.
      press(4'h2);
      press(4'h9);
      exp_q.push_back('{7'h44, 1'b0});
      press(4'h1);
      check("basic_a", a_out, 7'h2B);
      check("basic_b", b_out, 7'h19);
      check("basic_valid", result_valid, 1'b1);
      press(4'h0);
      check("done_to_alo", state_led, 3'd0);
      check("done_clears_valid", result_valid, 1'b0);

      // Overflow: 0x7F + 0x01 = 0x00 carry 1; y[3] of high nibble ignored.
      press(4'hF);
      press(4'hF);
      check("ovf_a", a_out, 7'h7F);
      press(4'h1);
      exp_q.push_back('{7'h00, 1'b1});
      press(4'h0);
      check("ovf_b", b_out, 7'h01);
      press(4'h0);

      // Clear precedence in S_B_LO with A=0x2B.
      press(4'hB);
      press(4'h2);
      check("pre_clear_state", state_led, 3'd2);
      check("pre_clear_a", a_out, 7'h2B);
      @(negedge clk);
      pb_next = 1'b1; pb_clear = 1'b1;
      repeat (10) @(negedge clk);
      pb_next = 1'b0; pb_clear = 1'b0;
      repeat (10) @(negedge clk);
      check("clr_state", state_led, 3'd0);
      check("clr_a", a_out, 7'h00);
      check("clr_b", b_out, 7'h01 & 7'h00);
      check("clr_sum_cout_valid", {sum, cout, result_valid}, 9'h000);

      // Async reset in the third cycle of S_ADD.
      press(4'h3);
      press(4'h0);
      press(4'h4);
      @(negedge clk);
      y = 4'h0;
      pb_next = 1'b1;
      wait_state(3'd4, 20, "enter_add");
      @(posedge clk);
      @(posedge clk);
      #2;
      check("pre_rst_a", a_out, 7'h03);
      rst_n = 1'b0;
      #1;
      check("async_state", state_led, 3'd0);
      check("async_a_b", {a_out, b_out}, 14'h0000);
      check("async_sum_cout_valid", {sum, cout, result_valid}, 9'h000);
      pb_next = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_state", state_led, 3'd0);

      // Press during S_ADD on the short-debounce instance: 0x05 + 0x03.
      press2(4'h5);
      press2(4'h0);
      press2(4'h3);
      check("d2_state_bhi", st2, 3'd3);
      @(negedge clk);
      y = 4'h0;
      pb_next2 = 1'b1;
      repeat (2) @(negedge clk);
      pb_next2 = 1'b0;
      repeat (2) @(negedge clk);
      pb_next2 = 1'b1;
      add2 = 0;
      for (int i = 0; i < 30 && !rv2; i++) begin
         @(negedge clk);
         if (st2 == 3'd4) add2++;
      end
      check("d2_valid", rv2, 1'b1);
      check("d2_state_done", st2, 3'd5);
      check("d2_add_cycles", add2, 7);
      check("d2_sum", {cout2, sum2}, 8'h08);
      repeat (10) @(negedge clk);
      check("d2_held_stays_done", st2, 3'd5);
      pb_next2 = 1'b0;
      repeat (5) @(negedge clk);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_load_controller.md
# adder_load_controller

Clocked controller that sequences operand entry and addition for the 7-bit adder lab datapath. It replaces four raw pushbutton clocks with one debounced "next" button and one "clear" button. A state machine steps through loading A[3:0], A[6:4], B[3:0] and B[6:4] from the 4-bit switch bus. It then computes A+B bit-serially, one full-add per cycle, and holds the 7-bit sum and carry-out for the board LEDs.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed to accept a button level change (≥2; board build overrides to ~500000).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pb_next  input  1  raw "next" pushbutton, asynchronous to clk, bouncy.
- pb_clear  input  1  raw "clear" pushbutton, asynchronous to clk, bouncy.
- y  input  4  switch bus; sampled on an accepted next press.
- a_out  output  7  operand A register.
- b_out  output  7  operand B register.
- sum  output  7  result register.
- cout  output  1  carry out of bit 6.
- result_valid  output  1  high while sum/cout hold a completed result.
- state_led  output  3  current state encoding (see below).

## Operation
- Each button has its own conditioner: a 2-flop synchronizer feeding a debouncer, then a rising-edge detector.
  - The debouncer counter increments every cycle the synchronized level differs from the debounced level, and clears when they match.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter clears.
  - The edge detector produces a 1-cycle press pulse on a 0→1 change of the debounced level. Releases produce no pulse.
- FSM states and state_led codes: S_A_LO=0, S_A_HI=1, S_B_LO=2, S_B_HI=3, S_ADD=4, S_DONE=5. Codes 6 and 7 are unreachable; if entered, the FSM goes to S_A_LO on the next cycle.
- Next-press actions:
  - S_A_LO: a[3:0]←y, go to S_A_HI.
  - S_A_HI: a[6:4]←y[2:0] (y[3] ignored), go to S_B_LO.
  - S_B_LO: b[3:0]←y, go to S_B_HI.
  - S_B_HI: b[6:4]←y[2:0], then sum←0, carry←0, bit index←0, result_valid←0; go to S_ADD.
  - S_ADD: next presses are ignored, not queued.
  - S_DONE: go to S_A_LO and clear result_valid. a, b, sum and cout are retained, so partial reloads overwrite only the selected nibble.
- S_ADD, each cycle:
  - sum[i]←a[i]^b[i]^carry.
  - carry←majority(a[i],b[i],carry).
  - i←i+1.
  - When i=6: cout←final carry, result_valid←1, go to S_DONE.
- Arithmetic is unsigned modulo 128; the carry out of bit 6 appears on cout.
- Clear press, in any state: a, b, sum, cout and result_valid go to 0; FSM goes to S_A_LO. A clear press in the same cycle as a next press wins; the next press is discarded.
- Reset values (rst_n low): all outputs 0, state S_A_LO, debounced levels 0, counters 0, synchronizers 0.

## Timing
- A raw pb edge held stable gives a debounced change 2+DEBOUNCE_CYCLES cycles later. The press pulse is high in the following cycle, for exactly 1 cycle.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no pulse.
- The edge registering the S_B_HI press enters S_ADD. S_ADD lasts exactly 7 cycles. result_valid rises on the 7th clock edge after entering S_ADD, together with the S_DONE entry.
- sum bits update one per cycle during S_ADD. Intermediate values are visible on sum and are not valid while result_valid=0.
- Reset asserted mid-S_ADD clears everything immediately, with no clock needed. After release, the FSM is in S_A_LO.
- Button held continuously produces one press only; a new press requires a debounced release first.

## Test plan
- Basic add (DEBOUNCE_CYCLES=4): enter y=0xB,0x2,0x9,0x1 with next presses, so a_out=0x2B and b_out=0x19. Required: 7 cycles later sum=0x44, cout=0, result_valid=1, state_led=5.
- Overflow: A=0x7F (y=0xF,0xF), B=0x01 (y=0x1,0x0). Required: sum=0x00, cout=1. The y[3]=1 in the second entry is ignored, so a_out=0x7F.
- Bounce rejection (DEBOUNCE_CYCLES=4): toggle pb_next high/low for 3 cycles each, 10 times. Required: state_led stays 0, a_out stays 0. Holding high afterwards gives exactly one transition to state 1.
- Press during S_ADD: issue a valid next press 2 cycles into S_ADD. Required: result_valid still rises after 7 cycles; state is S_DONE, not S_A_LO.
- Clear precedence: debounced clear and next press in the same cycle while in S_B_LO with a_out=0x2B. Required: state_led=0, a_out=b_out=sum=0, cout=0, result_valid=0.
- Async reset mid-add: drive rst_n low at cycle 3 of S_ADD, between clock edges. Required: all outputs 0 immediately; state_led=0 after release.
